router_pkt_tx: RTL and testbench

Packet source that drives the input side of the 1x3 router (pkt_valid, data_in, busy).
- Host preloads payload bytes into an internal buffer, then issues a start with a destination.
- The block serialises the packet: header {len[5:0], dest[1:0]}, then payload, then the XOR parity byte. It obeys router busy back-pressure and enforces an inter-packet gap.
- Used as the stimulus/host front end for router_top and as a reusable packet master.

---
 rtl/router_pkt_tx.sv | 153 +++++++++++++++
 tb/tb_router_pkt_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: host-loaded packet master for the 1x3 router input port.
// The host fills a payload buffer, then requests a start with a destination.
// The block sends the header {len,dest}, then the payload bytes, then the
// XOR parity byte, honouring router busy, and then idles for IPG cycles.
module router_pkt_tx #(
    parameter int MAX_LEN = 63,
    parameter int IPG     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld_en,
    input  logic [7:0] ld_data,
    output logic       ld_rdy,
    output logic [5:0] cnt,
    input  logic       start,
    input  logic [1:0] dest,
    input  logic       corrupt_par,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       tx_busy,
    output logic       done,
    output logic       req_err
);

    // Width of the gap counter; at least one bit so IPG of 0 or 1 still elaborates.
    localparam int         GW       = (IPG > 1) ? $clog2(IPG) : 1;
    localparam logic [5:0] MAX_CNT  = 6'(MAX_LEN);
    localparam logic [GW-1:0] GAP_LAST = GW'(IPG - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PLD,
        PAR,
        GAP
    } state_t;

    // Request fields captured when a start is accepted.
    typedef struct packed {
        logic [5:0] len;
        logic [1:0] dst;
        logic       corrupt;
    } req_t;

    state_t        state;
    req_t          req;
    logic [5:0]    idx;
    logic [7:0]    par;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    mem [MAX_LEN];

    logic start_ok;
    logic load_fire;
    logic last_byte;

    // A start wins over a load in the same cycle; a rejected start also drops the load.
    assign start_ok  = start && (cnt != 6'd0) && (dest != 2'd3);
    assign ld_rdy    = (state == IDLE) && (cnt < MAX_CNT);
    assign load_fire = ld_en && ld_rdy && !start;
    assign tx_busy   = (state != IDLE);
    assign last_byte = (idx == req.len - 6'd1);

    // Payload storage; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_fire)
            mem[cnt] <= ld_data;
    end

    // Transmit FSM with registered router-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req       <= '0;
            cnt       <= '0;
            idx       <= '0;
            par       <= '0;
            gap_cnt   <= '0;
            pkt_valid <= 1'b0;
            data_out  <= '0;
            done      <= 1'b0;
            req_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            req_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            req.len     <= cnt;
                            req.dst     <= dest;
                            req.corrupt <= corrupt_par;
                            par         <= {cnt, dest};
                            data_out    <= {cnt, dest};
                            pkt_valid   <= 1'b1;
                            state       <= HDR;
                        end else begin
                            req_err <= 1'b1;
                        end
                    end else if (load_fire) begin
                        cnt <= cnt + 6'd1;
                    end
                end
                HDR: begin
                    if (!busy) begin
                        idx      <= '0;
                        data_out <= mem[0];
                        state    <= PLD;
                    end
                end
                PLD: begin
                    if (!busy) begin
                        par <= par ^ data_out;
                        if (last_byte) begin
                            pkt_valid <= 1'b0;
                            data_out  <= par ^ data_out ^ {8{req.corrupt}};
                            state     <= PAR;
                        end else begin
                            idx      <= idx + 6'd1;
                            data_out <= mem[idx + 6'd1];
                        end
                    end
                end
                PAR: begin
                    if (!busy) begin
                        data_out <= '0;
                        gap_cnt  <= '0;
                        if (IPG == 0) begin
                            cnt   <= '0;
                            idx   <= '0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: checks outputs one cycle at a time,
// #1 after each rising edge, against hand-computed byte streams.
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_en;
    logic [7:0] ld_data;
    logic       ld_rdy;
    logic [5:0] cnt;
    logic       start;
    logic [1:0] dest;
    logic       corrupt_par;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_busy;
    logic       done;
    logic       req_err;

    int n_chk  = 0;
    int n_pass = 0;

    router_pkt_tx #(.MAX_LEN(63), .IPG(2)) dut (
        .clk(clk), .rst(rst),
        .ld_en(ld_en), .ld_data(ld_data), .ld_rdy(ld_rdy), .cnt(cnt),
        .start(start), .dest(dest), .corrupt_par(corrupt_par), .busy(busy),
        .pkt_valid(pkt_valid), .data_out(data_out), .tx_busy(tx_busy),
        .done(done), .req_err(req_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] b);
        ld_en   = 1'b1;
        ld_data = b;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] d, input logic cp);
        start       = 1'b1;
        dest        = d;
        corrupt_par = cp;
        tick();
        start       = 1'b0;
        corrupt_par = 1'b0;
    endtask

    // Check the byte currently presented, then choose busy for the next edge.
    task automatic expect_out(input string tag, input logic pv, input logic [7:0] d, input logic b);
        chk({tag, "_pv"}, pkt_valid, pv);
        chk({tag, "_data"}, data_out, d);
        busy = b;
        tick();
        busy = 1'b0;
    endtask

    // Two gap cycles, then the done pulse with the buffer emptied.
    task automatic expect_tail(input string tag);
        expect_out({tag, "_gap0"}, 1'b0, 8'h00, 1'b0);
        expect_out({tag, "_gap1"}, 1'b0, 8'h00, 1'b0);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_cnt0"}, cnt, 6'd0);
        chk({tag, "_idle"}, tx_busy, 1'b0);
        tick();
        chk({tag, "_done_drop"}, done, 1'b0);
    endtask

    initial begin
        rst = 1'b1; ld_en = 1'b0; ld_data = '0; start = 1'b0;
        dest = '0; corrupt_par = 1'b0; busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pv", pkt_valid, 1'b0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_done", done, 1'b0);
        chk("rst_err", req_err, 1'b0);
        chk("rst_txb", tx_busy, 1'b0);
        chk("rst_ldrdy", ld_rdy, 1'b1);
        chk("rst_cnt", cnt, 6'd0);
        rst = 1'b0;
        tick();

        // Start with an empty buffer is rejected.
        do_start(2'd1, 1'b0);
        chk("empty_err", req_err, 1'b1);
        chk("empty_pv", pkt_valid, 1'b0);
        chk("empty_txb", tx_busy, 1'b0);
        tick();
        chk("empty_err_drop", req_err, 1'b0);

        // Basic 3-byte packet, no back-pressure.
        load(8'h11); load(8'h22); load(8'h33);
        chk("t1_cnt", cnt, 6'd3);
        do_start(2'd1, 1'b0);
        chk("t1_txb", tx_busy, 1'b1);
        chk("t1_ldrdy", ld_rdy, 1'b0);
        expect_out("t1_hdr", 1'b1, 8'h0D, 1'b0);
        expect_out("t1_b0", 1'b1, 8'h11, 1'b0);
        expect_out("t1_b1", 1'b1, 8'h22, 1'b0);
        expect_out("t1_b2", 1'b1, 8'h33, 1'b0);
        expect_out("t1_par", 1'b0, 8'h0D, 1'b0);
        expect_tail("t1");

        // Same packet with stalls; a stray start mid-packet must be ignored.
        load(8'h11); load(8'h22); load(8'h33);
        do_start(2'd1, 1'b0);
        expect_out("t2_hdr", 1'b1, 8'h0D, 1'b0);
        expect_out("t2_b0s", 1'b1, 8'h11, 1'b1);
        expect_out("t2_b0", 1'b1, 8'h11, 1'b0);
        start = 1'b1;
        expect_out("t2_b1s0", 1'b1, 8'h22, 1'b1);
        start = 1'b0;
        chk("t2_no_err", req_err, 1'b0);
        expect_out("t2_b1s1", 1'b1, 8'h22, 1'b1);
        expect_out("t2_b1s2", 1'b1, 8'h22, 1'b1);
        expect_out("t2_b1", 1'b1, 8'h22, 1'b0);
        expect_out("t2_b2", 1'b1, 8'h33, 1'b0);
        expect_out("t2_pars", 1'b0, 8'h0D, 1'b1);
        expect_out("t2_par", 1'b0, 8'h0D, 1'b0);
        expect_tail("t2");

        // Parity corruption on a 1-byte packet to port 2.
        load(8'hA5);
        do_start(2'd2, 1'b1);
        expect_out("t3_hdr", 1'b1, 8'h06, 1'b0);
        expect_out("t3_b0", 1'b1, 8'hA5, 1'b0);
        expect_out("t3_par", 1'b0, 8'h5C, 1'b0);
        expect_tail("t3");

        // dest=3 rejected with the buffer kept, then sent to port 0.
        load(8'h0F); load(8'hF0);
        do_start(2'd3, 1'b0);
        chk("t4_err", req_err, 1'b1);
        chk("t4_pv", pkt_valid, 1'b0);
        chk("t4_cnt", cnt, 6'd2);
        tick();
        chk("t4_err_drop", req_err, 1'b0);
        do_start(2'd0, 1'b0);
        expect_out("t4_hdr", 1'b1, 8'h08, 1'b0);
        expect_out("t4_b0", 1'b1, 8'h0F, 1'b0);
        expect_out("t4_b1", 1'b1, 8'hF0, 1'b0);
        expect_out("t4_par", 1'b0, 8'hF7, 1'b0);
        expect_tail("t4");

        // Full buffer: 63 bytes, 64th dropped, max-length packet.
        for (int i = 0; i < 63; i++) load(8'(i));
        chk("t5_cnt", cnt, 6'd63);
        chk("t5_ldrdy", ld_rdy, 1'b0);
        load(8'h99);
        chk("t5_cnt_sat", cnt, 6'd63);
        do_start(2'd0, 1'b0);
        expect_out("t5_hdr", 1'b1, 8'hFC, 1'b0);
        for (int i = 0; i < 63; i++) expect_out($sformatf("t5_b%0d", i), 1'b1, 8'(i), 1'b0);
        expect_out("t5_par", 1'b0, 8'hC3, 1'b0);
        expect_tail("t5");

        // Reset during payload byte 5 aborts at once.
        for (int i = 0; i < 8; i++) load(8'h80 + 8'(i));
        do_start(2'd1, 1'b0);
        expect_out("t6_hdr", 1'b1, 8'h21, 1'b0);
        for (int i = 0; i < 5; i++) expect_out($sformatf("t6_b%0d", i), 1'b1, 8'h80 + 8'(i), 1'b0);
        chk("t6_b5", data_out, 8'h85);
        rst = 1'b1;
        #1;
        chk("t6_rst_pv", pkt_valid, 1'b0);
        chk("t6_rst_cnt", cnt, 6'd0);
        chk("t6_rst_txb", tx_busy, 1'b0);
        chk("t6_rst_ldrdy", ld_rdy, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        load(8'h3C);
        do_start(2'd2, 1'b0);
        expect_out("t6_hdr2", 1'b1, 8'h06, 1'b0);
        expect_out("t6_pb0", 1'b1, 8'h3C, 1'b0);
        expect_out("t6_par", 1'b0, 8'h3A, 1'b0);
        expect_tail("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
